// File: rtl/hall_request_queue_if.sv
// rtl/hall_request_queue_if.sv - request/response bundle between hall call capture, queue and controller
//
// Purpose : groups the request-capture and head-of-queue handshake signals of
//           hall_request_queue so they travel as one port.
// Signals : req_valid_input/src_input/dest_input/direction_input  request in
//           req_accept/req_reject/reject_code                       per-request verdict
//           out_valid/out_ready                                     head handshake
//           src_output/dest_output/direction_output                 head entry fields
// Modports: slave  - the queue (consumes requests, drives head)
//           master - the environment (drives requests and out_ready)
interface hall_request_queue_if #(
   parameter int FLOOR_W = 3
);
   logic               req_valid_input;
   logic [FLOOR_W-1:0] src_input;
   logic [FLOOR_W-1:0] dest_input;
   logic               direction_input;
   logic               req_accept;
   logic               req_reject;
   logic [1:0]         reject_code;
   logic               out_valid;
   logic               out_ready;
   logic [FLOOR_W-1:0] src_output;
   logic [FLOOR_W-1:0] dest_output;
   logic               direction_output;

   modport slave (
      input  req_valid_input, src_input, dest_input, direction_input, out_ready,
      output req_accept, req_reject, reject_code,
      output out_valid, src_output, dest_output, direction_output
   );

   modport master (
      output req_valid_input, src_input, dest_input, direction_input, out_ready,
      input  req_accept, req_reject, reject_code,
      input  out_valid, src_output, dest_output, direction_output
   );
endinterface

// File: rtl/hall_request_queue.sv
// rtl/hall_request_queue.sv - validating FIFO of passenger hall requests for the elevator controller
//
// Purpose : validates (src, dest, direction) requests, buffers accepted ones in
//           a DEPTH-entry FIFO and presents the head with a first-word
//           fall-through valid/ready handshake. Rejections are reported with a
//           reason code and counted in a saturating drop counter.
// Ports   : clk        - rising-edge clock
//           rst        - asynchronous active-high reset
//           bus        - hall_request_queue_if.slave (request in, verdict, head out)
//           level      - number of entries held (0..DEPTH)
//           drop_count - saturating count of rejected requests
// Option  : HALL_REQUEST_QUEUE_DEDUP_EN - reject requests identical to any held entry.
module hall_request_queue #(
   parameter int FLOOR_W    = 3,
   parameter int NUM_FLOORS = 8,
   parameter int DEPTH      = 4,
   parameter int CNT_W      = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   hall_request_queue_if.slave      bus,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         drop_count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int ENT_W = 2 * FLOOR_W + 1;
   localparam logic [FLOOR_W:0] FLOOR_LIMIT = (FLOOR_W + 1)'(NUM_FLOORS);
   localparam logic [PTR_W:0]   FULL_LEVEL  = (PTR_W + 1)'(DEPTH);

   // Entries packed as {src, dest, direction}.
   logic [ENT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n;
   logic [PTR_W:0]   level_n;
   logic [ENT_W-1:0] in_entry, head_n;
   logic             pop, push, full, dup_hit;
   logic             bad_range, bad_same, bad_dir;
   logic             reject_n;
   logic [1:0]       code_n;

   assign in_entry = {bus.src_input, bus.dest_input, bus.direction_input};

`ifdef HALL_REQUEST_QUEUE_DEDUP_EN
   // Slot i is occupied when its distance past rd_ptr is below level. The head
   // still counts on an edge where it is being popped.
   always_comb begin
      dup_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (({1'b0, PTR_W'(i) - rd_ptr} < level) && (mem[i] == in_entry)) begin
            dup_hit = 1'b1;
         end
      end
   end
`else
   assign dup_hit = 1'b0;
`endif

   always_comb begin
      pop       = bus.out_valid & bus.out_ready;
      full      = (level == FULL_LEVEL);
      bad_range = ({1'b0, bus.src_input} >= FLOOR_LIMIT) || ({1'b0, bus.dest_input} >= FLOOR_LIMIT);
      bad_same  = (bus.src_input == bus.dest_input);
      bad_dir   = bus.direction_input ? (bus.src_input > bus.dest_input)
                                      : (bus.src_input < bus.dest_input);
      reject_n  = 1'b0;
      code_n    = 2'b00;
      push      = 1'b0;

      // Checks in priority order; the first failure supplies the code.
      if (bus.req_valid_input) begin
         if (bad_range) begin
            reject_n = 1'b1;
            code_n   = 2'b11;
         end else if (bad_same) begin
            reject_n = 1'b1;
            code_n   = 2'b01;
         end else if (bad_dir) begin
            reject_n = 1'b1;
            code_n   = 2'b10;
         end else if (dup_hit || (full && !pop)) begin
            reject_n = 1'b1;
            code_n   = 2'b00;
         end else begin
            push = 1'b1;
         end
      end

      rd_ptr_n = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
      wr_ptr_n = push ? wr_ptr + PTR_W'(1) : wr_ptr;

      level_n = level;
      if (push && !pop) begin
         level_n = level + (PTR_W + 1)'(1);
      end else if (pop && !push) begin
         level_n = level - (PTR_W + 1)'(1);
      end

      // The next head lives at rd_ptr_n. If that slot is the one being written
      // this edge (empty queue, or level=1 with pop), bypass the incoming entry.
      if (push && (rd_ptr_n == wr_ptr)) begin
         head_n = in_entry;
      end else begin
         head_n = mem[rd_ptr_n];
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_entry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr               <= '0;
         wr_ptr               <= '0;
         level                <= '0;
         drop_count           <= '0;
         bus.req_accept       <= 1'b0;
         bus.req_reject       <= 1'b0;
         bus.reject_code      <= 2'b00;
         bus.out_valid        <= 1'b0;
         bus.src_output       <= '0;
         bus.dest_output      <= '0;
         bus.direction_output <= 1'b0;
      end else begin
         rd_ptr          <= rd_ptr_n;
         wr_ptr          <= wr_ptr_n;
         level           <= level_n;
         bus.req_accept  <= push;
         bus.req_reject  <= reject_n;
         bus.reject_code <= code_n;
         bus.out_valid   <= (level_n != '0);
         // Head fields only move when a new entry becomes head, so they hold
         // while the controller stalls.
         if (level_n != '0) begin
            {bus.src_output, bus.dest_output, bus.direction_output} <= head_n;
         end
         if (reject_n && (drop_count != '1)) begin
            drop_count <= drop_count + CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_hall_request_queue.sv
// tb/tb_hall_request_queue.sv - self-checking bench for hall_request_queue
module tb_hall_request_queue;
   localparam int FLOOR_W    = 4;
   localparam int NUM_FLOORS = 8;
   localparam int DEPTH      = 4;
   localparam int CNT_W      = 3;
   localparam int LVL_W      = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic [LVL_W-1:0] level;
   logic [CNT_W-1:0] drop_count;
   int               n_checks = 0;
   int               n_fail   = 0;

   hall_request_queue_if #(.FLOOR_W(FLOOR_W)) bus ();

   hall_request_queue #(
      .FLOOR_W(FLOOR_W), .NUM_FLOORS(NUM_FLOORS), .DEPTH(DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .level(level), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       v;  int s; int d; logic dir; logic rdy;
      logic       acc; logic rej; logic [1:0] code;
      logic       ov; int hs; int hd; logic hdir; int lvl; int drop;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(logic v, int s, int d, logic dir, logic rdy,
                               logic acc, logic rej, logic [1:0] code,
                               logic ov, int hs, int hd, logic hdir, int lvl, int drop);
      vec_t e;
      e.v = v; e.s = s; e.d = d; e.dir = dir; e.rdy = rdy;
      e.acc = acc; e.rej = rej; e.code = code;
      e.ov = ov; e.hs = hs; e.hd = hd; e.hdir = hdir; e.lvl = lvl; e.drop = drop;
      vecs.push_back(e);
   endfunction

   task automatic drive(logic v, int s, int d, logic dir, logic rdy);
      bus.req_valid_input = v;
      bus.src_input       = FLOOR_W'(s);
      bus.dest_input      = FLOOR_W'(d);
      bus.direction_input = dir;
      bus.out_ready       = rdy;
   endtask

   task automatic step(logic v, int s, int d, logic dir, logic rdy);
      drive(v, s, d, dir, rdy);
      @(posedge clk);
      #1;
   endtask

   task automatic check(string name, logic acc, logic rej, logic [1:0] code,
                        logic ov, int hs, int hd, logic hdir, int lvl, int drop);
      logic ok;
      n_checks++;
      ok = (bus.req_accept === acc) && (bus.req_reject === rej) && (bus.reject_code === code)
           && (bus.out_valid === ov) && (level === LVL_W'(lvl)) && (drop_count === CNT_W'(drop));
      // Head fields are meaningful only while out_valid is expected.
      if (ov) begin
         ok = ok && (bus.src_output === FLOOR_W'(hs)) && (bus.dest_output === FLOOR_W'(hd))
                 && (bus.direction_output === hdir);
      end
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got acc=%0b rej=%0b code=%0b valid=%0b head=(%0d,%0d,%0b) level=%0d drop=%0d; want acc=%0b rej=%0b code=%0b valid=%0b head=(%0d,%0d,%0b) level=%0d drop=%0d",
                  name, bus.req_accept, bus.req_reject, bus.reject_code, bus.out_valid,
                  bus.src_output, bus.dest_output, bus.direction_output, level, drop_count,
                  acc, rej, code, ov, hs, hd, hdir, lvl, drop);
      end
   endtask

   initial begin
      //   v  s  d dir rdy  acc rej code  ov hs hd hdir lvl drop
      add(1, 1, 5, 1, 0,   1, 0, 2'b00, 1, 1, 5, 1,  1,  0);  // first push, FWFT head
      add(1, 3, 3, 1, 0,   0, 1, 2'b01, 1, 1, 5, 1,  1,  1);  // same floor
      add(1, 5, 2, 1, 0,   0, 1, 2'b10, 1, 1, 5, 1,  1,  2);  // up but src>dest
      add(1, 1, 9, 1, 0,   0, 1, 2'b11, 1, 1, 5, 1,  1,  3);  // out of range
      add(1, 9, 9, 0, 0,   0, 1, 2'b11, 1, 1, 5, 1,  1,  4);  // range beats same-floor
      add(0, 0, 0, 0, 0,   0, 0, 2'b00, 1, 1, 5, 1,  1,  4);  // idle, head stable
      add(1, 2, 4, 1, 0,   1, 0, 2'b00, 1, 1, 5, 1,  2,  4);
      add(1, 6, 0, 0, 0,   1, 0, 2'b00, 1, 1, 5, 1,  3,  4);
      add(1, 0, 7, 1, 0,   1, 0, 2'b00, 1, 1, 5, 1,  4,  4);  // full
      add(1, 3, 1, 0, 0,   0, 1, 2'b00, 1, 1, 5, 1,  4,  5);  // full, no pop
      add(1, 3, 1, 0, 1,   1, 0, 2'b00, 1, 2, 4, 1,  4,  5);  // full, push+pop
      add(0, 0, 0, 0, 1,   0, 0, 2'b00, 1, 6, 0, 0,  3,  5);  // drain
      add(0, 0, 0, 0, 1,   0, 0, 2'b00, 1, 0, 7, 1,  2,  5);
      add(0, 0, 0, 0, 1,   0, 0, 2'b00, 1, 3, 1, 0,  1,  5);
      add(0, 0, 0, 0, 1,   0, 0, 2'b00, 0, 0, 0, 0,  0,  5);  // empty
      add(0, 0, 0, 0, 1,   0, 0, 2'b00, 0, 0, 0, 0,  0,  5);  // ready while empty ignored
      add(1, 0, 1, 1, 0,   1, 0, 2'b00, 1, 0, 1, 1,  1,  5);  // refill across wrap
      add(1, 1, 2, 1, 0,   1, 0, 2'b00, 1, 0, 1, 1,  2,  5);
      add(1, 2, 3, 1, 0,   1, 0, 2'b00, 1, 0, 1, 1,  3,  5);
      add(1, 7, 6, 0, 0,   1, 0, 2'b00, 1, 0, 1, 1,  4,  5);
      add(1, 4, 5, 1, 1,   1, 0, 2'b00, 1, 1, 2, 1,  4,  5);
      add(0, 0, 0, 0, 1,   0, 0, 2'b00, 1, 2, 3, 1,  3,  5);
      add(0, 0, 0, 0, 1,   0, 0, 2'b00, 1, 7, 6, 0,  2,  5);
      add(0, 0, 0, 0, 1,   0, 0, 2'b00, 1, 4, 5, 1,  1,  5);
      add(0, 0, 0, 0, 1,   0, 0, 2'b00, 0, 0, 0, 0,  0,  5);
      add(1, 5, 6, 1, 0,   1, 0, 2'b00, 1, 5, 6, 1,  1,  5);
      add(1, 6, 7, 1, 1,   1, 0, 2'b00, 1, 6, 7, 1,  1,  5);  // level=1 push+pop
      add(0, 0, 0, 0, 1,   0, 0, 2'b00, 0, 0, 0, 0,  0,  5);
      add(1, 4, 4, 1, 0,   0, 1, 2'b01, 0, 0, 0, 0,  0,  6);
      add(1, 6, 1, 1, 0,   0, 1, 2'b10, 0, 0, 0, 0,  0,  7);
      add(1, 8, 1, 0, 0,   0, 1, 2'b11, 0, 0, 0, 0,  0,  7);  // drop saturates
      add(1, 2, 2, 0, 0,   0, 1, 2'b01, 0, 0, 0, 0,  0,  7);
      add(1, 2, 5, 0, 0,   0, 1, 2'b10, 0, 0, 0, 0,  0,  7);  // down but src<dest

      rst = 1'b1;
      drive(0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].v, vecs[i].s, vecs[i].d, vecs[i].dir, vecs[i].rdy);
         check($sformatf("vec%0d", i), vecs[i].acc, vecs[i].rej, vecs[i].code, vecs[i].ov,
               vecs[i].hs, vecs[i].hd, vecs[i].hdir, vecs[i].lvl, vecs[i].drop);
      end

      // Asynchronous reset mid-stream with three entries held.
      step(1, 1, 3, 1, 0);
      step(1, 4, 2, 0, 0);
      step(1, 0, 5, 1, 0);
      check("pre_reset", 1, 0, 2'b00, 1, 1, 3, 1, 3, 7);
      #2;
      rst = 1'b1;
      #1;
      check("async_reset", 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
      drive(1, 2, 6, 1, 0);            // lost: sampled while reset is held
      @(posedge clk);
      #1;
      check("req_during_reset", 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      step(1, 3, 6, 1, 0);
      check("post_reset_push", 1, 0, 2'b00, 1, 3, 6, 1, 1, 0);
      step(0, 0, 0, 0, 1);
      check("post_reset_pop", 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);

      // Identical requests, including one against the head popped the same edge.
      step(1, 2, 6, 1, 0);
      check("dup_first", 1, 0, 2'b00, 1, 2, 6, 1, 1, 0);
      step(1, 2, 6, 1, 0);
`ifdef HALL_REQUEST_QUEUE_DEDUP_EN
      check("dup_second", 0, 1, 2'b00, 1, 2, 6, 1, 1, 1);
      step(1, 2, 6, 1, 1);
      check("dup_vs_popped_head", 0, 1, 2'b00, 0, 0, 0, 0, 0, 2);
`else
      check("dup_second", 1, 0, 2'b00, 1, 2, 6, 1, 2, 0);
      step(1, 2, 6, 1, 1);
      check("dup_vs_popped_head", 1, 0, 2'b00, 1, 2, 6, 1, 2, 0);
`endif

      drive(0, 0, 0, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/hall_request_queue.md
Name: hall_request_queue

Overview:
- Upstream of the elevator controller.
- Captures passenger requests (source floor, destination floor, direction), validates them and buffers them in a FIFO.
- Presents requests one at a time to the controller over a valid/ready handshake, replacing the controller's ad-hoc set_clk strobe.
- Rejects malformed requests and requests that arrive when the queue is full, and reports why.

Parameters:
- FLOOR_W, 3, width of floor fields.
- NUM_FLOORS, 8, legal floors are 0..NUM_FLOORS-1; must be <= 2^FLOOR_W.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid_input  input  1  request present this cycle.
- src_input  input  FLOOR_W  source floor.
- dest_input  input  FLOOR_W  destination floor.
- direction_input  input  1  1 = up, 0 = down.
- req_accept  output  1  one-cycle pulse: the request sampled this edge was enqueued.
- req_reject  output  1  one-cycle pulse: the request sampled this edge was discarded.
- reject_code  output  2  reason, valid while req_reject=1: 01 src==dest, 10 direction mismatch, 11 floor out of range, 00 queue full or duplicate.
- out_valid  output  1  head entry available.
- out_ready  input  1  controller takes the head entry.
- src_output  output  FLOOR_W  head source floor.
- dest_output  output  FLOOR_W  head destination floor.
- direction_output  output  1  head direction.
- level  output  clog2(DEPTH)+1  entries held.
- drop_count  output  CNT_W  saturating count of rejected requests.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - req_accept, req_reject, reject_code, out_valid, src_output, dest_output, direction_output, level and drop_count all go to 0.
  - Read and write pointers clear.
  - A request in flight during reset is lost; it is neither accepted nor counted.
- Validation, first failing check wins:
  - Floor range: src_input or dest_input >= NUM_FLOORS gives code 11.
  - Same floor: src_input == dest_input gives code 01.
  - Direction: direction_input=1 with src>dest, or direction_input=0 with src<dest, gives code 10.
  - Capacity: queue full and no pop this cycle gives code 00.
- Accept or reject:
  - Each edge with req_valid_input=1 produces exactly one of req_accept or req_reject in the following cycle.
  - With req_valid_input=0 neither pulses.
- Push and pop:
  - Pop occurs on an edge where out_valid=1 and out_ready=1.
  - Push occurs when the request passes validation and (level<DEPTH or a pop occurs the same edge). Simultaneous push and pop while full is legal and leaves level=DEPTH.
  - Simultaneous push and pop while level=1 is also legal: the new entry becomes head and out_valid stays 1.
- Output timing:
  - Head fields are registered and first-word fall-through.
  - A request pushed into an empty queue shows out_valid=1 on the cycle after the accepting edge: one-cycle latency.
  - Head fields stay stable while out_valid=1 and out_ready=0.
  - out_ready while out_valid=0 is ignored.
- Ordering: strict FIFO; pointers wrap modulo DEPTH.
- level: +1 on push-only, -1 on pop-only, unchanged on both or neither; never exceeds DEPTH and never goes below 0.
- drop_count: +1 per req_reject and saturates at all-ones (no wrap).

Optional Feature:
- Macro HALL_REQUEST_QUEUE_DEDUP_EN.
- When defined:
  - A valid request whose (src, dest, direction) equals any entry currently held is rejected with reject_code 00 and counted in drop_count.
  - The comparison covers all occupied entries, including the head being popped on the same edge; that entry still counts as present.
- When undefined: duplicates are enqueued like any other request.

Test Plan:
- Reset then push (src=1, dest=5, up) with out_ready=0 -> req_accept pulse next cycle; out_valid=1 with src_output=1, dest_output=5, direction_output=1; level=1.
- Push (3, 3, up); push (5, 2, up); push (1, 9, up) with NUM_FLOORS=8 -> req_reject with codes 01, 10, 11; drop_count=3; level unchanged.
- Push 4 valid requests with out_ready=0, then a fifth -> fifth rejected with code 00; level=4. Repeat the fifth with out_ready=1 on the same edge -> accepted, level stays 4, head advances to entry 2.
- Fill the queue, drain with out_ready=1 continuously, then refill across the pointer wrap -> outputs emerge in exact push order and level returns to 0 with out_valid=0.
- Assert rst mid-stream with level=3 -> all outputs 0 immediately (before the next edge); a subsequent push appears as the sole entry.
- With HALL_REQUEST_QUEUE_DEDUP_EN: push (2, 6, up) twice -> second rejected with code 00 and drop_count=1. Without the macro -> both accepted, level=2.
